e_mdu_ctrl: RTL

E_MDU_CTRL -- requirements
Module: e_mdu_ctrl

---
 rtl/e_mdu_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/e_mdu_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// e_mdu_ctrl
// Multi-cycle multiply/divide unit controller for the E stage. Accepts
// mult/multu/div/divu, computes the full 64-bit result at the accepting edge
// into pending registers, then holds busy for a fixed latency before
// committing to HI/LO. mthi/mtlo write HI/LO directly in a single cycle.
//
// Parameters
//   MULT_CYC  busy cycles for mult/multu
//   DIV_CYC   busy cycles for div/divu
// Ports
//   clk      in   sole clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   start    in   E-stage op valid this cycle
//   md_op    in   [2:0] 0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 rsvd
//   a        in   [31:0] rs operand
//   b        in   [31:0] rt operand
//   cancel   in   abort any in-flight mult/div; blocks any start this cycle
//   busy     out  registered, high while a mult/div is in flight
//   stall    out  busy | (start & md_op in 1..4); independent of cancel
//   hi, lo   out  [31:0] registered HI/LO
// -----------------------------------------------------------------------------
module e_mdu_ctrl #(
   parameter int unsigned MULT_CYC = 5,
   parameter int unsigned DIV_CYC  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cancel,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int unsigned CNT_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_e;

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6,
      OP_RSVD  = 3'd7
   } md_op_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic [31:0]   hi_q, hi_d, lo_q, lo_d;
   logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

   md_op_e        op;
   logic          op_md;
   logic [31:0]   res_hi, res_lo;
   logic [63:0]   prod_s, prod_u;

   assign op    = md_op_e'(md_op);
   assign op_md = (op == OP_MULT) || (op == OP_MULTU) ||
                  (op == OP_DIV)  || (op == OP_DIVU);

   assign busy  = busy_q;
   assign stall = busy_q | (start & op_md);
   assign hi    = hi_q;
   assign lo    = lo_q;

   assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign prod_u = {32'd0, a} * {32'd0, b};

   // Full result of the candidate op, computed from the live operands; it is
   // only captured at the accepting edge, so later operand changes are moot.
   // Divide-by-zero and the signed overflow case are resolved explicitly so
   // the divider expression is never evaluated on them.
   always_comb begin
      res_hi = '0;
      res_lo = '0;
      case (op)
         OP_MULT: begin
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
         end
         OP_MULTU: begin
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
         end
         OP_DIV: begin
            if (b == '0) begin
               res_hi = a;
               res_lo = '1;
            end else if ((a == 32'h8000_0000) && (b == '1)) begin
               res_hi = '0;
               res_lo = 32'h8000_0000;
            end else begin
               res_hi = $signed(a) % $signed(b);
               res_lo = $signed(a) / $signed(b);
            end
         end
         OP_DIVU: begin
            if (b == '0) begin
               res_hi = a;
               res_lo = '1;
            end else begin
               res_hi = a % b;
               res_lo = a / b;
            end
         end
         default: begin
            res_hi = '0;
            res_lo = '0;
         end
      endcase
   end

   // Next-state / next-value logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;

      case (state_q)
         IDLE: begin
            if (start && !cancel) begin
               case (op)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     pend_hi_d = res_hi;
                     pend_lo_d = res_lo;
                     cnt_d     = ((op == OP_MULT) || (op == OP_MULTU)) ?
                                 CW'(MULT_CYC) : CW'(DIV_CYC);
                     busy_d    = 1'b1;
                     state_d   = RUN;
                  end
                  OP_MTHI: hi_d = a;
                  OP_MTLO: lo_d = a;
                  default: ;
               endcase
            end
         end

         RUN: begin
            if (cancel) begin
               state_d   = IDLE;
               cnt_d     = '0;
               busy_d    = 1'b0;
               pend_hi_d = '0;
               pend_lo_d = '0;
            end else if (cnt_q <= CW'(1)) begin
               // This edge takes cnt to zero: commit and free the unit at once
               hi_d    = pend_hi_q;
               lo_d    = pend_lo_q;
               cnt_d   = '0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
      end
   end

endmodule
